seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu_pkg.sv | 21 ++
 rtl/seq_alu_md.sv | 83 ++++++++
 rtl/seq_alu.sv | 103 ++++++++++
 tb/tb_seq_alu.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/seq_alu_pkg.sv
// Shared ALUOp encodings and controller state type for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_SRL   = 4'b0100;
    localparam logic [3:0] OP_SRA   = 4'b0101;
    localparam logic [3:0] OP_SLT   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_alu_md.sv
// Iterative unsigned multiply (shift-and-add) / divide (restoring), one bit per cycle.
// done is combinational on the last iteration; res_lo/res_hi carry that iteration's result.
module seq_alu_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int CW = $clog2(WIDTH);

    logic             run;
    logic             div;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    // Divide: hi holds the partial remainder, lo shifts dividend out and quotient in.
    // Multiply: {hi,lo} is the product register with the multiplier in lo.
    always_comb begin
        sum     = {1'b0, hi} + {1'b0, opnd};
        shifted = {hi, lo[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        next_hi = hi;
        next_lo = lo;
        if (div) begin
            if (!diff[WIDTH]) begin
                next_hi = diff[WIDTH-1:0];
                next_lo = {lo[WIDTH-2:0], 1'b1};
            end else begin
                next_hi = shifted[WIDTH-1:0];
                next_lo = {lo[WIDTH-2:0], 1'b0};
            end
        end else if (lo[0]) begin
            next_hi = sum[WIDTH:1];
            next_lo = {sum[0], lo[WIDTH-1:1]};
        end else begin
            next_hi = {1'b0, hi[WIDTH-1:1]};
            next_lo = {hi[0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            run  <= 1'b0;
            div  <= 1'b0;
            cnt  <= '0;
            hi   <= '0;
            lo   <= '0;
            opnd <= '0;
        end else if (start) begin
            run  <= 1'b1;
            div  <= is_div;
            cnt  <= '0;
            hi   <= '0;
            lo   <= a;
            opnd <= b;
        end else if (run) begin
            hi  <= next_hi;
            lo  <= next_lo;
            cnt <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end

    assign done   = run && (cnt == CW'(WIDTH - 1));
    assign res_lo = next_lo;
    assign res_hi = next_hi;

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops latency 1, multu/divu latency WIDTH+1.
// No backpressure; start is ignored while busy and results hold until the next done.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] HI
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             multi;
    logic             md_done;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] alu_c;
    logic [WIDTH-1:0] alu_hi;
    logic [SHW-1:0]   shamt;

    assign shamt  = B[SHW-1:0];
    assign accept = start && (state != S_CALC);
    // divu by zero is resolved in the single-cycle path instead of iterating.
    assign multi  = (ALUOp == OP_MULTU) || ((ALUOp == OP_DIVU) && (B != '0));

    always_comb begin
        alu_c  = '0;
        alu_hi = '0;
        case (ALUOp)
            OP_ADD:  alu_c = A + B;
            OP_SUB:  alu_c = A - B;
            OP_AND:  alu_c = A & B;
            OP_OR:   alu_c = A | B;
            OP_SRL:  alu_c = A >> shamt;
            OP_SRA:  alu_c = $signed(A) >>> shamt;
            OP_SLT:  alu_c = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: alu_c = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_DIVU: begin
                alu_c  = '1;
                alu_hi = A;
            end
            default: ;
        endcase
    end

    seq_alu_md #(.WIDTH(WIDTH)) u_md (
        .clk    (clk),
        .reset  (reset),
        .start  (accept && multi),
        .is_div (ALUOp == OP_DIVU),
        .a      (A),
        .b      (B),
        .done   (md_done),
        .res_lo (md_lo),
        .res_hi (md_hi)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) next_state = multi ? S_CALC : S_DONE;
                else       next_state = S_IDLE;
            end
            S_CALC:  if (md_done) next_state = S_DONE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            C  <= '0;
            HI <= '0;
        end else if (accept && !multi) begin
            C  <= alu_c;
            HI <= alu_hi;
        end else if ((state == S_CALC) && md_done) begin
            C  <= md_lo;
            HI <= md_hi;
        end
    end

    assign busy = (state == S_CALC);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_seq_alu.sv
// Directed and random checks of seq_alu (WIDTH=32) against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUOp;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] C;
    logic [31:0] HI;

    int n_cmp = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .ALUOp (ALUOp),
        .start (start),
        .busy  (busy),
        .done  (done),
        .C     (C),
        .HI    (HI)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain arithmetic, latency from the operation class.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] c, output logic [31:0] h, output int lat);
        logic [63:0] prod;
        int s;
        s   = int'(b % 32);
        c   = 32'h0;
        h   = 32'h0;
        lat = 1;
        case (op)
            4'd0: c = a + b;
            4'd1: c = a - b;
            4'd2: c = a & b;
            4'd3: c = a | b;
            4'd4: c = a >> s;
            4'd5: c = (a >> s) | ((a >= 32'h8000_0000) ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd6: c = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd7: c = (a < b) ? 32'd1 : 32'd0;
            4'd8: begin
                prod = 64'(a) * 64'(b);
                c    = prod[31:0];
                h    = prod[63:32];
                lat  = 33;
            end
            4'd9: begin
                if (b == 0) begin
                    c = 32'hFFFF_FFFF;
                    h = a;
                end else begin
                    c   = a / b;
                    h   = a % b;
                    lat = 33;
                end
            end
            default: ;
        endcase
    endtask

    // Issue one op, scramble inputs after acceptance, then measure latency and results.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string tag);
        logic [31:0] ec;
        logic [31:0] eh;
        int elat;
        int n;
        int nbusy;
        model(op, a, b, ec, eh, elat);
        ALUOp = op; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        A = $urandom; B = $urandom; ALUOp = 4'($urandom);
        n = 1;
        nbusy = 0;
        while (!done && n < 100) begin
            if (busy) nbusy++;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'(elat));
        chk({tag, " busy_cycles"}, 64'(nbusy), 64'(elat - 1));
        chk({tag, " C"}, 64'(C), 64'(ec));
        chk({tag, " HI"}, 64'(HI), 64'(eh));
        @(posedge clk); #1;
        chk({tag, " done_pulse"}, 64'(done), 64'(0));
        chk({tag, " C_hold"}, 64'(C), 64'(ec));
    endtask

    initial begin
        logic [31:0] ec;
        logic [31:0] eh;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        int elat;
        int n;

        reset = 1'b1; start = 1'b0; A = '0; B = '0; ALUOp = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'(0));
        chk("reset done", 64'(done), 64'(0));
        chk("reset C", 64'(C), 64'(0));
        chk("reset HI", 64'(HI), 64'(0));
        reset = 1'b0;

        run_op(4'b0101, 32'hffff0000, 32'h00000003, "sra");
        run_op(4'b0100, 32'hffff0000, 32'h00000003, "srl");
        run_op(4'b1000, 32'hffffffff, 32'h00000002, "multu");
        run_op(4'b1001, 32'd100, 32'd7, "divu");
        run_op(4'b1001, 32'd5, 32'd0, "divu_by_zero");
        run_op(4'b1111, 32'h1234, 32'h5678, "undefined_op");
        run_op(4'b0001, 32'h0, 32'h1, "sub_wrap");
        run_op(4'b0110, 32'h80000000, 32'h1, "slt_neg");

        // start with add while a multu is in progress must be ignored
        model(4'b1000, 32'h12345678, 32'h9, ec, eh, elat);
        ALUOp = 4'b1000; A = 32'h12345678; B = 32'h9; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        repeat (3) begin @(posedge clk); #1; n++; end
        ALUOp = 4'b0000; A = 32'd1; B = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        n++;
        start = 1'b0;
        while (!done && n < 100) begin @(posedge clk); #1; n++; end
        chk("busy_ignore latency", 64'(n), 64'(elat));
        chk("busy_ignore C", 64'(C), 64'(ec));
        chk("busy_ignore HI", 64'(HI), 64'(eh));
        @(posedge clk); #1;
        chk("busy_ignore no_extra_done", 64'(done), 64'(0));
        chk("busy_ignore C_hold", 64'(C), 64'(ec));

        // reset mid-divide, with a start in the reset cycle
        ALUOp = 4'b1001; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1; start = 1'b1; ALUOp = 4'b0000; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk("abort busy", 64'(busy), 64'(0));
        chk("abort done", 64'(done), 64'(0));
        chk("abort C", 64'(C), 64'(0));
        chk("abort HI", 64'(HI), 64'(0));
        repeat (40) begin
            @(posedge clk); #1;
            chk("abort no_done", 64'(done), 64'(0));
        end
        run_op(4'b0000, 32'hffffffff, 32'h1, "add_after_reset");

        // back-to-back single-cycle ops with start held
        A = 32'h1; B = 32'hffffffff; start = 1'b1;
        ALUOp = 4'b0010;
        @(posedge clk); #1;
        chk("b2b and done", 64'(done), 64'(1));
        chk("b2b and C", 64'(C), 64'(32'h1));
        ALUOp = 4'b0011;
        @(posedge clk); #1;
        chk("b2b or done", 64'(done), 64'(1));
        chk("b2b or C", 64'(C), 64'(32'hffffffff));
        ALUOp = 4'b0111;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b sltu done", 64'(done), 64'(1));
        chk("b2b sltu C", 64'(C), 64'(32'h1));
        @(posedge clk); #1;
        chk("b2b end done", 64'(done), 64'(0));

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'hffffffff;
            run_op(rop, ra, rb, $sformatf("rand%0d op%0d", i, rop));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
